serial_mult_ctrl: RTL and testbench
===================================

SERIAL_MULT_CTRL -- requirements
Module: serial_mult_ctrl

Interface
REQ-001 Parameter: N, default 4, operand width in bits; supported range 2..8.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request a multiply; sampled only in IDLE.
REQ-005 a  input  N  multiplicand, unsigned; captured on accepted start.
REQ-006 b  input  N  multiplier, unsigned; captured on accepted start.
REQ-007 busy  output  1  high while an operation is in progress (ADD/SHIFT states).
REQ-008 done  output  1  one-cycle pulse, product valid.
REQ-009 product  output  2N  unsigned a*b; holds last result until next accepted start.

Function
REQ-010 The block SHALL compute a*b by shift-and-add using exactly one instance of the team's 1-bit full-adder cell (adder_1bit), applied bit-serially; no other adder logic.
REQ-011 Registers: M[N-1:0] (multiplicand), A[N-1:0] (accumulator high), Q[N-1:0] (multiplier/product low), C (1-bit carry-out), cy (serial carry flop), bit counter bcnt, iteration counter icnt.
REQ-012 States: IDLE, ADD, SHIFT, DONE; one-hot or binary encoding is an implementation choice.
REQ-013 IDLE: on start=1, load M<=a, Q<=b, A<=0, C<=0, cy<=0, bcnt<=0, icnt<=0, go to ADD; otherwise stay.
REQ-014 ADD (N cycles per iteration): adder inputs a=A[0], b=(Q[0] ? M[bcnt] : 0), cin=cy; A<={sum, A[N-1:1]}; cy<=cout; bcnt increments.
REQ-015 On the ADD cycle with bcnt=N-1: C<=cout, cy<=0, bcnt<=0, go to SHIFT.
REQ-016 SHIFT (1 cycle): {C,A,Q}<={0,C,A,Q[N-1:1]}; icnt increments; if icnt=N-1 go to DONE, else go to ADD.
REQ-017 ADD phase SHALL run all N cycles even when Q[0]=0 (addend forced to 0), giving data-independent latency.
REQ-018 DONE (1 cycle): done=1, product<={A,Q}; unconditionally return to IDLE.
REQ-019 Latency: start sampled at edge k -> done high in the cycle following edge k+N*(N+1); N=4: 20 cycles busy, done in 21st cycle after start edge.
REQ-020 busy=1 exactly in ADD and SHIFT; busy=0 in IDLE and DONE; done and busy never high together.
REQ-021 start while busy or in DONE SHALL be ignored; no queuing; a and b changes after capture have no effect.
REQ-022 Back-to-back: start held high continuously SHALL begin a new operation on the first IDLE cycle after DONE (one IDLE cycle between operations).
REQ-023 Arithmetic: unsigned, no overflow possible; max result (2^N-1)^2 fits 2N bits.
REQ-024 product output SHALL be a register updated only in DONE; stable at all other times.

Reset
REQ-025 rst_n=0 at any time, including mid-operation, SHALL immediately force state IDLE, busy=0, done=0, product=0, and clear M, A, Q, C, cy, bcnt, icnt.
REQ-026 After rst_n deasserts, the block SHALL accept start on the first rising edge where rst_n=1.
REQ-027 An operation interrupted by reset SHALL produce no done pulse and leave product=0.

Verification
REQ-028 N=4, a=4'hF, b=4'hF, start one cycle -> busy high 20 cycles, done pulse in 21st cycle, product=8'hE1.
REQ-029 N=4, a=0, b=4'hB and a=4'h7, b=0 -> product=8'h00, same 21-cycle latency each.
REQ-030 N=4, a=4'h5, b=4'h3 start; pulse start again at cycles 5 and 21 -> both ignored, single done, product=8'h0F.
REQ-031 N=4, start held high, a=4'h6,b=4'h7 then a=4'h9,b=4'h2 -> done pulses 22 cycles apart, product 8'h2A then 8'h12.
REQ-032 N=4, a=4'hD, b=4'hA, assert rst_n=0 at cycle 10 -> busy/done/product=0 asynchronously; new start a=4'h3,b=4'h4 -> product=8'h0C.
REQ-033 Exhaustive N=4 sweep of all 256 operand pairs against a reference model -> every product matches, done exactly once per start.

Source files
------------

// File: rtl/serial_mult_ctrl.sv
// Bit-serial shift-and-add unsigned multiplier built around a single 1-bit full adder.
// Each of the N iterations spends N cycles on a serial add, then one cycle on a shift.

module adder_1bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_mult_ctrl #(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product
);
  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, ADD, SHIFT, DONE} state_t;

  state_t        state;
  logic [N-1:0]  m_reg;
  logic [N-1:0]  a_reg;
  logic [N-1:0]  q_reg;
  logic          c_reg;
  logic          cy;
  logic [CW-1:0] bcnt;
  logic [CW-1:0] icnt;
  logic          addend;
  logic          fa_sum;
  logic          fa_cout;

  // The addend is forced to zero when the multiplier bit is clear, so latency never depends on data.
  assign addend = q_reg[0] ? m_reg[bcnt] : 1'b0;

  adder_1bit u_fa (
    .a   (a_reg[0]),
    .b   (addend),
    .cin (cy),
    .sum (fa_sum),
    .cout(fa_cout)
  );

  // The accumulator rotates through the adder LSB-first; after N cycles its bits are back in place.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      m_reg   <= '0;
      a_reg   <= '0;
      q_reg   <= '0;
      c_reg   <= 1'b0;
      cy      <= 1'b0;
      bcnt    <= '0;
      icnt    <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            m_reg <= a;
            q_reg <= b;
            a_reg <= '0;
            c_reg <= 1'b0;
            cy    <= 1'b0;
            bcnt  <= '0;
            icnt  <= '0;
            busy  <= 1'b1;
            state <= ADD;
          end
        end
        ADD: begin
          a_reg <= {fa_sum, a_reg[N-1:1]};
          if (bcnt == LAST) begin
            c_reg <= fa_cout;
            cy    <= 1'b0;
            bcnt  <= '0;
            state <= SHIFT;
          end else begin
            cy   <= fa_cout;
            bcnt <= bcnt + 1'b1;
          end
        end
        SHIFT: begin
          {c_reg, a_reg, q_reg} <= {1'b0, c_reg, a_reg, q_reg[N-1:1]};
          icnt <= icnt + 1'b1;
          if (icnt == LAST) begin
            // Capture the post-shift value so product is already valid while done is high.
            product <= {c_reg, a_reg, q_reg[N-1:1]};
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= DONE;
          end else begin
            state <= ADD;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_mult_ctrl.sv
// Scoreboard bench for serial_mult_ctrl (N=4): expected products are queued at start
// and popped when done pulses; latency, busy width, ignore-start and reset are checked.

module tb_serial_mult_ctrl;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [N-1:0]   a = '0;
  logic [N-1:0]   b = '0;
  logic           busy;
  logic           done;
  logic [2*N-1:0] product;

  int vectors = 0;
  int miscompares = 0;
  logic [2*N-1:0] exp_q[$];

  always #5 clk = ~clk;

  serial_mult_ctrl #(.N(N)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .product(product)
  );

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [2*N-1:0] pop_expected();
    if (exp_q.size() == 0) return 'x;
    return exp_q.pop_front();
  endfunction

  // Caller must already be at a falling edge; the next rising edge samples start.
  task automatic issue(input logic [N-1:0] av, input logic [N-1:0] bv);
    a = av;
    b = bv;
    start = 1'b1;
    exp_q.push_back({{N{1'b0}}, av} * {{N{1'b0}}, bv});
  endtask

  // Counts falling edges after the start edge until done (or a 40-cycle budget expires).
  task automatic measure(input bit hold, output int cycles, output int busy_cnt, output int overlap);
    cycles = 0;
    busy_cnt = 0;
    overlap = 0;
    do begin
      @(negedge clk);
      cycles++;
      if (!hold && cycles == 1) start = 1'b0;
      if (busy === 1'b1) busy_cnt++;
      if (busy === 1'b1 && done === 1'b1) overlap++;
    end while (done !== 1'b1 && cycles < 40);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy: got %b, expected 0", busy); end
    vectors++;
    if (done !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_done: got %b, expected 0", done); end
    vectors++;
    if (product !== 8'h00) begin miscompares++; $display("[TB] FAIL reset_product: got %h, expected 00", product); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_max_operands();
    int cyc, bc, ov;
    logic [2*N-1:0] exp;
    @(negedge clk);
    issue(4'hF, 4'hF);
    measure(1'b0, cyc, bc, ov);
    exp = pop_expected();
    vectors++;
    if (cyc !== 21) begin miscompares++; $display("[TB] FAIL max_latency: got %0d, expected 21", cyc); end
    vectors++;
    if (bc !== 20) begin miscompares++; $display("[TB] FAIL max_busy_cycles: got %0d, expected 20", bc); end
    vectors++;
    if (ov !== 0) begin miscompares++; $display("[TB] FAIL max_busy_done_overlap: got %0d, expected 0", ov); end
    vectors++;
    if (product !== exp) begin miscompares++; $display("[TB] FAIL max_product: got %h, expected %h", product, exp); end
    @(negedge clk);
    vectors++;
    if (done !== 1'b0) begin miscompares++; $display("[TB] FAIL max_done_width: got %b, expected 0", done); end
    vectors++;
    if (product !== 8'hE1) begin miscompares++; $display("[TB] FAIL max_product_hold: got %h, expected e1", product); end
  endtask

  task automatic test_zero_operands();
    logic [N-1:0] av [2] = '{4'h0, 4'h7};
    logic [N-1:0] bv [2] = '{4'hB, 4'h0};
    int cyc, bc, ov;
    logic [2*N-1:0] exp;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      issue(av[i], bv[i]);
      measure(1'b0, cyc, bc, ov);
      exp = pop_expected();
      vectors++;
      if (cyc !== 21) begin miscompares++; $display("[TB] FAIL zero_latency[%0d]: got %0d, expected 21", i, cyc); end
      vectors++;
      if (product !== exp) begin miscompares++; $display("[TB] FAIL zero_product[%0d]: got %h, expected %h", i, product, exp); end
      @(negedge clk);
    end
  endtask

  task automatic test_ignore_start();
    int done_cnt, done_at;
    logic [2*N-1:0] exp;
    done_cnt = 0;
    done_at = 0;
    @(negedge clk);
    issue(4'h5, 4'h3);
    for (int c = 1; c <= 50; c++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        done_cnt++;
        done_at = c;
        exp = pop_expected();
        vectors++;
        if (product !== exp) begin miscompares++; $display("[TB] FAIL ignore_product: got %h, expected %h", product, exp); end
      end
      if (c == 2) begin a = 4'hF; b = 4'hF; end
      start = (c == 5 || c == 21);
    end
    vectors++;
    if (done_cnt !== 1) begin miscompares++; $display("[TB] FAIL ignore_done_count: got %0d, expected 1", done_cnt); end
    vectors++;
    if (done_at !== 21) begin miscompares++; $display("[TB] FAIL ignore_done_cycle: got %0d, expected 21", done_at); end
    vectors++;
    if (product !== 8'h0F) begin miscompares++; $display("[TB] FAIL ignore_product_final: got %h, expected 0f", product); end
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL ignore_busy_final: got %b, expected 0", busy); end
  endtask

  task automatic test_back_to_back();
    int times[$];
    logic [2*N-1:0] exp;
    @(negedge clk);
    issue(4'h6, 4'h7);
    exp_q.push_back(8'd9 * 8'd2);
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (c == 2) begin a = 4'h9; b = 4'h2; end
      if (c == 23) start = 1'b0;
      if (done === 1'b1) begin
        times.push_back(c);
        exp = pop_expected();
        vectors++;
        if (product !== exp) begin miscompares++; $display("[TB] FAIL b2b_product: got %h, expected %h", product, exp); end
      end
    end
    vectors++;
    if (times.size() !== 2) begin
      miscompares++;
      $display("[TB] FAIL b2b_done_count: got %0d, expected 2", times.size());
    end else begin
      vectors++;
      if (times[0] !== 21) begin miscompares++; $display("[TB] FAIL b2b_first_done: got %0d, expected 21", times[0]); end
      vectors++;
      if (times[1] - times[0] !== 22) begin
        miscompares++;
        $display("[TB] FAIL b2b_spacing: got %0d, expected 22", times[1] - times[0]);
      end
    end
    vectors++;
    if (product !== 8'h12) begin miscompares++; $display("[TB] FAIL b2b_product_final: got %h, expected 12", product); end
  endtask

  task automatic test_reset_mid_op();
    int cyc, bc, ov, spurious;
    logic [2*N-1:0] exp;
    spurious = 0;
    @(negedge clk);
    issue(4'hD, 4'hA);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL midrst_busy: got %b, expected 0", busy); end
    vectors++;
    if (done !== 1'b0) begin miscompares++; $display("[TB] FAIL midrst_done: got %b, expected 0", done); end
    vectors++;
    if (product !== 8'h00) begin miscompares++; $display("[TB] FAIL midrst_product: got %h, expected 00", product); end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (done !== 1'b0) spurious++;
    end
    vectors++;
    if (spurious !== 0) begin miscompares++; $display("[TB] FAIL midrst_spurious_done: got %0d, expected 0", spurious); end
    @(negedge clk);
    rst_n = 1'b1;
    issue(4'h3, 4'h4);
    measure(1'b0, cyc, bc, ov);
    exp = pop_expected();
    vectors++;
    if (cyc !== 21) begin miscompares++; $display("[TB] FAIL midrst_restart_latency: got %0d, expected 21", cyc); end
    vectors++;
    if (product !== exp) begin miscompares++; $display("[TB] FAIL midrst_restart_product: got %h, expected %h", product, exp); end
  endtask

  task automatic test_exhaustive();
    int cyc, bc, ov;
    logic [2*N-1:0] exp;
    for (int ai = 0; ai < 16; ai++) begin
      for (int bi = 0; bi < 16; bi++) begin
        @(negedge clk);
        issue(N'(ai), N'(bi));
        measure(1'b0, cyc, bc, ov);
        exp = pop_expected();
        vectors++;
        if (product !== exp) begin
          miscompares++;
          $display("[TB] FAIL sweep_product a=%h b=%h: got %h, expected %h", ai[3:0], bi[3:0], product, exp);
        end
        vectors++;
        if (cyc !== 21) begin
          miscompares++;
          $display("[TB] FAIL sweep_latency a=%h b=%h: got %0d, expected 21", ai[3:0], bi[3:0], cyc);
        end
        @(negedge clk);
        vectors++;
        if (done !== 1'b0) begin
          miscompares++;
          $display("[TB] FAIL sweep_done_once a=%h b=%h: got %b, expected 0", ai[3:0], bi[3:0], done);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_max_operands();
    test_zero_operands();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid_op();
    test_exhaustive();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
